// File: rtl/ram_sync_init.sv
// Single-port synchronous RAM reloaded from the INIT image after every reset.
// Define RAM_FWD_EN for write-first behaviour on a same-address store+load.
module ram_sync_init #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter logic [DEPTH*DATA_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write,
    input  logic              str,
    input  logic              ld,
    output logic [DATA_W-1:0] read,
    output logic              rd_vld,
    output logic              busy,
    output logic              addr_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] RELOAD = 1'b0;
    localparam logic [0:0] READY  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem      [DEPTH];
    logic [DATA_W-1:0] init_mem [DEPTH];

    logic              in_range;
    logic              accept;
    logic              we;
    logic [IW-1:0]     a_idx;
    logic [IW-1:0]     c_idx;
    logic [IW-1:0]     w_idx;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] rd_word;

    // Word 0 sits in the MSBs of the flat image.
    for (genvar g = 0; g < DEPTH; g++) begin : g_init
        assign init_mem[g] = INIT[(DEPTH-1-g)*DATA_W +: DATA_W];
    end

    assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
    assign accept   = (state == READY);
    assign busy     = (state == RELOAD);
    assign a_idx    = IW'(addr);
    assign c_idx    = IW'(cnt);

    always_comb begin
        we     = 1'b0;
        w_idx  = a_idx;
        w_data = write;
        if (!rst) begin
            if (state == RELOAD) begin
                we     = 1'b1;
                w_idx  = c_idx;
                w_data = init_mem[c_idx];
            end else if (str && in_range) begin
                we = 1'b1;
            end
        end
    end

`ifdef RAM_FWD_EN
    assign rd_word = str ? write : mem[a_idx];
`else
    assign rd_word = mem[a_idx];
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_idx] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RELOAD;
            cnt      <= '0;
            read     <= '0;
            rd_vld   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_vld   <= 1'b0;
            addr_err <= 1'b0;
            if (!accept) begin
                cnt <= cnt + 1'b1;
                if (cnt == (ADDR_W+1)'(DEPTH-1)) begin
                    state <= READY;
                end
            end else begin
                if (ld) begin
                    rd_vld <= 1'b1;
                    read   <= in_range ? rd_word : '0;
                end
                if ((ld || str) && !in_range) begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sync_init.sv
// Bench for ram_sync_init: a DEPTH=8 and a DEPTH=6 instance share stimulus
// and are checked against an array model of reload, store and load rules.
module tb_ram_sync_init;

    localparam int DW = 20;
    localparam int AW = 3;
`ifdef RAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [8*DW-1:0] INIT_A = {20'hABCDE, {7{20'h0}}};
    localparam logic [6*DW-1:0] INIT_B =
        {20'h11111, 20'h0, 20'h0, 20'h33333, 20'h0, 20'h0};

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] write;
    logic          str;
    logic          ld;

    logic [DW-1:0] read_a, read_b;
    logic          rd_vld_a, rd_vld_b;
    logic          busy_a, busy_b;
    logic          addr_err_a, addr_err_b;

    int n_chk = 0;
    int n_err = 0;

    int          dep  [2];
    logic [DW-1:0] iw [2][8];
    logic [DW-1:0] mm [2][8];
    int          brem [2];
    logic [DW-1:0] mrd [2];
    logic        mvld [2];
    logic        merr [2];

    always #5 clk = ~clk;

    ram_sync_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .INIT(INIT_A)) u_a (
        .clk(clk), .rst(rst), .addr(addr), .write(write), .str(str), .ld(ld),
        .read(read_a), .rd_vld(rd_vld_a), .busy(busy_a), .addr_err(addr_err_a)
    );

    ram_sync_init #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(6), .INIT(INIT_B)) u_b (
        .clk(clk), .rst(rst), .addr(addr), .write(write), .str(str), .ld(ld),
        .read(read_b), .rd_vld(rd_vld_b), .busy(busy_b), .addr_err(addr_err_b)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " a.read"},     read_a,           mrd[0]);
        chk({tag, " a.rd_vld"},   DW'(rd_vld_a),    DW'(mvld[0]));
        chk({tag, " a.busy"},     DW'(busy_a),      DW'(brem[0] > 0));
        chk({tag, " a.addr_err"}, DW'(addr_err_a),  DW'(merr[0]));
        chk({tag, " b.read"},     read_b,           mrd[1]);
        chk({tag, " b.rd_vld"},   DW'(rd_vld_b),    DW'(mvld[1]));
        chk({tag, " b.busy"},     DW'(busy_b),      DW'(brem[1] > 0));
        chk({tag, " b.addr_err"}, DW'(addr_err_b),  DW'(merr[1]));
    endtask

    // Effect of one rising edge on each instance's observable state.
    task automatic model_edge(input logic s, input logic l,
                              input logic [AW-1:0] a, input logic [DW-1:0] w);
        for (int i = 0; i < 2; i++) begin
            mvld[i] = 1'b0;
            merr[i] = 1'b0;
            if (brem[i] > 0) begin
                mm[i][dep[i] - brem[i]] = iw[i][dep[i] - brem[i]];
                brem[i]--;
            end else begin
                bit inr;
                inr = int'(a) < dep[i];
                merr[i] = (s || l) && !inr;
                if (l) begin
                    mvld[i] = 1'b1;
                    if (!inr)          mrd[i] = '0;
                    else if (FWD && s) mrd[i] = w;
                    else               mrd[i] = mm[i][a];
                end
                if (s && inr) mm[i][a] = w;
            end
        end
    endtask

    task automatic cycle(input string tag, input logic s, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] w);
        str   = s;
        ld    = l;
        addr  = a;
        write = w;
        @(posedge clk);
        model_edge(s, l, a, w);
        #1;
        check_all(tag);
        str = 1'b0;
        ld  = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            brem[i] = dep[i];
            mrd[i]  = '0;
            mvld[i] = 1'b0;
            merr[i] = 1'b0;
        end
    endtask

    // Pulse rst for 2 ns starting 1 ns after an edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rw;
        logic          rs, rl;

        dep[0] = 8;
        dep[1] = 6;
        for (int k = 0; k < 8; k++) begin
            iw[0][k] = '0;
            iw[1][k] = '0;
            mm[0][k] = '0;
            mm[1][k] = '0;
        end
        iw[0][0] = 20'hABCDE;
        iw[1][0] = 20'h11111;
        iw[1][3] = 20'h33333;

        rst   = 1'b1;
        addr  = '0;
        write = '0;
        str   = 1'b0;
        ld    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #1;
        rst = 1'b0;

        // Reload window: store on 2nd edge and load on 3rd are dropped.
        cycle("rl0", 1'b0, 1'b0, 3'd0, '0);
        cycle("rl1", 1'b1, 1'b0, 3'd1, 20'h12345);
        cycle("rl2", 1'b0, 1'b1, 3'd0, '0);
        idle("rl", 5);

        cycle("ld0", 1'b0, 1'b1, 3'd0, '0);
        cycle("ld1", 1'b0, 1'b1, 3'd1, '0);
        cycle("ld3", 1'b0, 1'b1, 3'd3, '0);

        cycle("st1", 1'b1, 1'b0, 3'd1, 20'd202);
        cycle("st2", 1'b1, 1'b0, 3'd2, 20'd303);
        cycle("st3", 1'b1, 1'b0, 3'd3, 20'd404);
        cycle("ld3b", 1'b0, 1'b1, 3'd3, '0);
        cycle("ld2b", 1'b0, 1'b1, 3'd2, '0);
        cycle("hold", 1'b0, 1'b0, 3'd0, '0);

        cycle("stld5", 1'b1, 1'b1, 3'd5, 20'd555);
        cycle("ld5", 1'b0, 1'b1, 3'd5, '0);

        cycle("st7", 1'b1, 1'b0, 3'd7, 20'd777);
        cycle("ld7", 1'b0, 1'b1, 3'd7, '0);
        cycle("gap", 1'b0, 1'b0, 3'd0, '0);
        cycle("ld6", 1'b0, 1'b1, 3'd6, '0);
        for (int k = 0; k < 8; k++) cycle("scan", 1'b0, 1'b1, AW'(k), '0);

        for (int k = 0; k < 60; k++) begin
            rs = 1'($urandom);
            rl = 1'($urandom);
            ra = AW'($urandom_range(0, 7));
            rw = DW'($urandom);
            cycle("rand", rs, rl, ra, rw);
        end

        cycle("st4", 1'b1, 1'b0, 3'd4, 20'd99);
        cycle("ld4", 1'b0, 1'b1, 3'd4, '0);
        pulse_reset("midrst");
        idle("rl2", 8);
        cycle("ld4r", 1'b0, 1'b1, 3'd4, '0);
        cycle("ld0r", 1'b0, 1'b1, 3'd0, '0);

        // Reset in the middle of a reload restarts it from word 0.
        cycle("st0", 1'b1, 1'b0, 3'd0, 20'hFFFFF);
        pulse_reset("rst2");
        idle("rl3", 3);
        pulse_reset("rst3");
        idle("rl4", 8);
        for (int k = 0; k < 8; k++) cycle("scan2", 1'b0, 1'b1, AW'(k), '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ram_sync_init.md
Name: ram_sync_init

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 1024x20 data memory.
- Generalised in width and depth, with a registered read port carrying a valid flag.
- After every reset it reloads its whole contents from the INIT image, one word per cycle, and reports busy while doing so.
- Sits between the CPU load/store unit and the memory array; serves as both instruction memory and data memory.

Parameters:
- DATA_W, 20, word width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of words; any value 1..2^ADDR_W, power of two not required.
- INIT, {DEPTH*DATA_W{1'b0}}, flat reset image; word 0 occupies the MSBs [DEPTH*DATA_W-1 -: DATA_W].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- addr  input  ADDR_W  word address for str/ld.
- write  input  DATA_W  store data.
- str  input  1  store request.
- ld  input  1  load request.
- read  output  DATA_W  registered load data.
- rd_vld  output  1  read holds data for a load accepted on the previous edge.
- busy  output  1  reload in progress; requests are ignored.
- addr_err  output  1  registered flag: the previous accepted request had addr >= DEPTH.

Behaviour:
- Reset (async, while rst=1):
  - read=0, rd_vld=0, addr_err=0, busy=1.
  - Reload counter cleared to 0; FSM in RELOAD.
  - Array contents are not touched asynchronously.
- FSM RELOAD:
  - The k-th rising edge after rst deasserts (k=0..DEPTH-1) writes INIT word k to address k.
  - The edge writing word DEPTH-1 also clears busy and moves the FSM to READY.
  - busy is therefore high for exactly DEPTH edges after release.
- FSM READY:
  - A request is accepted on an edge only if busy=0 before that edge.
  - Requests presented while busy=1 are dropped silently, with no queueing.
- Store (str=1, addr<DEPTH): mem[addr] <= write on the edge.
- Load (ld=1, addr<DEPTH):
  - read <= mem[addr] and rd_vld <= 1 on the edge; latency 1 cycle.
  - When ld=0, rd_vld <= 0 and read holds its last value.
- Simultaneous str and ld to the same address: read-first (read returns the old word); see RAM_FWD_EN.
- Out-of-range (addr >= DEPTH) with str or ld:
  - Store is ignored; a load returns read=0 with rd_vld=1.
  - addr_err <= 1 for one cycle; otherwise addr_err <= 0.
- Reset mid-operation:
  - An in-flight load is discarded: rd_vld=0, read=0.
  - Reload restarts at word 0 and overwrites all prior stores.
  - Reset asserted mid-reload restarts the counter at 0.
- The reload counter is ADDR_W+1 bits wide, so DEPTH = 2^ADDR_W terminates without wrap.

Optional Feature:
- Macro: RAM_FWD_EN.
- Defined: write-first. A simultaneous str and ld to the same in-range address returns the new write value on read the next cycle, and the array is also updated.
- Undefined: read-first, returning the old contents.
- All other behaviour is identical either way.

Test Plan:
- DEPTH=8, INIT word0=20'hABCDE, rest 0; release rst -> busy=1 for 8 edges, then 0; ld addr 0 -> next cycle read=20'hABCDE, rd_vld=1.
- After reload: str addr1=202, addr2=303, addr3=404 on consecutive edges, then ld addr3, addr2 -> read=404 then 303, rd_vld high on both cycles.
- str=1, ld=1, addr=5, write=555 where mem[5]=0 -> read=0 without RAM_FWD_EN, read=555 with it; a later ld addr 5 -> 555 in both builds.
- ld addr 0 while busy=1 (3rd reload edge) -> rd_vld stays 0; a str during busy is lost, and the INIT value is read back after reload.
- DEPTH=6, ADDR_W=3: str addr 7 = 777, then ld addr 7 -> addr_err pulses 1 for one cycle each time; read=0 with rd_vld=1; mem[0..5] unchanged.
- str addr4=99, assert rst for 2 ns mid-cycle -> read/rd_vld go 0 immediately; after reload, ld addr4 -> INIT value 0, not 99.
